// File: rtl/mul_pkg.sv
// Shared types and helpers for the RV32M multiply sequencer: op encoding, FSM states,
// operand-sign mapping and result-word selection.
package mul_pkg;

  typedef enum logic [1:0] {
    OpMul    = 2'b00,
    OpMulh   = 2'b01,
    OpMulhsu = 2'b10,
    OpMulhu  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StBusy,
    StDone
  } mul_seq_state_e;

  // Bit 1: rs1 treated as signed, bit 0: rs2 treated as signed.
  function automatic logic [1:0] op_to_sign(mul_op_e op);
    logic [1:0] sign;
    unique case (op)
      OpMul:    sign = 2'b11;
      OpMulh:   sign = 2'b11;
      OpMulhsu: sign = 2'b10;
      OpMulhu:  sign = 2'b00;
      default:  sign = 2'b00;
    endcase
    return sign;
  endfunction

  function automatic logic [31:0] select_word(mul_op_e op, logic [63:0] prod);
    return (op == OpMul) ? prod[31:0] : prod[63:32];
  endfunction

endpackage

// File: rtl/mul_result_cache.sv
// One-entry product cache keyed on operands and sign mode; the low word matches regardless
// of sign, so a MUL lookup ignores the stored sign.
module mul_result_cache
  import mul_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [31:0] wr_a_i,
  input  logic [31:0] wr_b_i,
  input  logic [1:0]  wr_sign_i,
  input  logic [63:0] wr_prod_i,
  input  logic [31:0] lk_a_i,
  input  logic [31:0] lk_b_i,
  input  logic [1:0]  lk_sign_i,
  input  logic        lk_is_mul_i,
  output logic        hit_o,
  output logic [63:0] prod_o
);

  logic        valid_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  sign_q;
  logic [63:0] prod_q;
  logic        match;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= '0;
      prod_q  <= '0;
    end else if (wr_en_i) begin
      valid_q <= 1'b1;
      a_q     <= wr_a_i;
      b_q     <= wr_b_i;
      sign_q  <= wr_sign_i;
      prod_q  <= wr_prod_i;
    end
  end

  always_comb begin
    match = valid_q && (lk_a_i == a_q) && (lk_b_i == b_q) &&
            (lk_is_mul_i || (lk_sign_i == sign_q));
    hit_o = CACHE_EN && match;
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/mul_seq.sv
// Sequencer between execute-stage issue and the iterative multiplier: decodes the op, runs the
// request/product handshakes, serves repeated operand pairs from a one-entry result cache.
module mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned TAG_W    = 5,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             m_flush,
  output logic             m_in_valid,
  input  logic             m_in_ready,
  output logic [1:0]       m_sign,
  output logic [31:0]      m_a,
  output logic [31:0]      m_b,
  input  logic             m_out_valid,
  output logic             m_out_ready,
  input  logic [63:0]      m_prod
);

  mul_seq_state_e   state_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  mul_op_e          op_q;
  logic [1:0]       sign_q;
  logic [TAG_W-1:0] tag_q;
  logic [63:0]      res_q;
  logic             out_valid_q;
  logic             m_in_valid_q;
  logic             m_out_ready_q;

  mul_op_e          in_op_e;
  logic [1:0]       in_sign;
  logic             accept;
  logic             hit;
  logic             cache_wr;
  logic [63:0]      cache_prod;

  assign in_op_e  = mul_op_e'(in_op);
  assign in_sign  = op_to_sign(in_op_e);
  assign in_ready = !flush && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
  assign accept   = in_valid && in_ready;
  // A product landing in a flush cycle belongs to a killed op and must not be cached.
  assign cache_wr = m_out_ready_q && m_out_valid && !flush;

  mul_result_cache #(
    .CACHE_EN (CACHE_EN)
  ) u_cache (
    .clk_i       (clock),
    .rst_i       (reset),
    .wr_en_i     (cache_wr),
    .wr_a_i      (a_q),
    .wr_b_i      (b_q),
    .wr_sign_i   (sign_q),
    .wr_prod_i   (m_prod),
    .lk_a_i      (in_a),
    .lk_b_i      (in_b),
    .lk_sign_i   (in_sign),
    .lk_is_mul_i (in_op_e == OpMul),
    .hit_o       (hit),
    .prod_o      (cache_prod)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= OpMul;
      sign_q        <= '0;
      tag_q         <= '0;
      res_q         <= '0;
      out_valid_q   <= 1'b0;
      m_in_valid_q  <= 1'b0;
      m_out_ready_q <= 1'b0;
    end else if (flush) begin
      state_q       <= StIdle;
      out_valid_q   <= 1'b0;
      m_in_valid_q  <= 1'b0;
      m_out_ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if ((state_q == StDone) && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
          if (accept) begin
            a_q    <= in_a;
            b_q    <= in_b;
            op_q   <= in_op_e;
            sign_q <= in_sign;
            tag_q  <= in_tag;
            if (hit) begin
              res_q       <= cache_prod;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              m_in_valid_q <= 1'b1;
              state_q      <= StReq;
            end
          end
        end
        StReq: begin
          if (m_in_ready) begin
            m_in_valid_q  <= 1'b0;
            m_out_ready_q <= 1'b1;
            state_q       <= StBusy;
          end
        end
        StBusy: begin
          if (m_out_valid) begin
            res_q         <= m_prod;
            m_out_ready_q <= 1'b0;
            out_valid_q   <= 1'b1;
            state_q       <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = select_word(op_q, res_q);
  assign out_tag     = tag_q;
  assign m_flush     = flush;
  assign m_in_valid  = m_in_valid_q;
  assign m_out_ready = m_out_ready_q;
  assign m_a         = a_q;
  assign m_b         = b_q;
  assign m_sign      = sign_q;

  // A pending request and a pending result must both hold steady until taken.
  a_req_stable: assert property (@(posedge clock) disable iff (reset || flush)
    (m_in_valid && !m_in_ready) |=> (m_in_valid && $stable(m_a) && $stable(m_b) &&
                                     $stable(m_sign)));

  a_out_stable: assert property (@(posedge clock) disable iff (reset || flush)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_tag)));

endmodule

// File: doc/mul_seq.md
# mul_seq

Sequencer for the RV32M multiply unit. Sits between the execute-stage issue logic and the iterative radix-4 multiplier. It decodes MUL/MULH/MULHSU/MULHU into the multiplier's operand-sign controls and drives the multiplier's two handshakes. It selects the low or high result word and returns it tagged to writeback. A one-entry result cache serves back-to-back MULH+MUL pairs on identical operands without re-running the multiplier.

## Interface
Parameters:
- TAG_W, 5, width of destination tag carried with each op
- CACHE_EN, 1, 1 enables the result cache; 0 forces every op to miss

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high
- flush  in  1  pipeline kill; cancels any op in flight
- in_valid  in  1  op offered by issue
- in_ready  out  1  op accepted when in_valid & in_ready
- in_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- in_a, in_b  in  32  rs1, rs2
- in_tag  in  TAG_W  destination tag
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts
- out_data  out  32  selected result word
- out_tag  out  TAG_W  tag of the result
- m_flush  out  1  equals flush
- m_in_valid  out  1  request to multiplier
- m_in_ready  in  1  multiplier accepts
- m_sign  out  2  [1] rs1 signed, [0] rs2 signed
- m_a, m_b  out  32  multiplier operands
- m_out_valid  in  1  multiplier product valid
- m_out_ready  out  1  sequencer accepts product
- m_prod  in  64  full product

## Operation
- Sign map: MUL 11, MULH 11, MULHSU 10, MULHU 00.
- out_data is prod[31:0] for MUL and prod[63:32] otherwise.
- States: IDLE, REQ, BUSY, DONE.
- Accept condition: in_ready = !flush & (IDLE | (DONE & out_ready)). On accept, latch a, b, op, tag and the mapped sign.
- Cache hit: cache valid, a and b match the cached operands, and either op==MUL or the mapped sign equals the cached sign. The low word is sign-independent.
- On accept with a hit: load the cached product into the result register and go to DONE.
- On accept with a miss: go to REQ.
- REQ: m_in_valid=1 and m_a/m_b/m_sign are driven from the latch. On m_in_ready, go to BUSY.
- BUSY: m_out_ready=1. On m_out_valid, capture m_prod into the result register. Write the cache: a, b, sign, prod, valid=1. Go to DONE.
- DONE: out_valid=1 and out_data/out_tag are held stable. On out_ready, go to IDLE, or to the next op's REQ/DONE if a new op is accepted in the same cycle.
- Flush, in any state: next state is IDLE and the latched op is discarded.
  - in_ready is 0 during the flush cycle, so no op is accepted.
  - A product arriving in the flush cycle is not written to the cache.
  - A cache entry already written stays valid.
- CACHE_EN=0: the hit term is forced to 0.

## Timing
- Reset values: state IDLE, cache valid 0, out_valid 0, m_in_valid 0, m_out_ready 0. in_ready is 1 after reset whenever flush=0.
- Hit latency: accept in cycle N, out_valid in cycle N+1.
- Miss latency:
  - Accept in cycle N, m_in_valid in N+1.
  - If the multiplier handshake completes in cycle M, out_valid rises in M+1.
- m_in_valid and the operands stay stable in REQ until m_in_ready. The sequencer never drops a request except on flush.
- Back-to-back ops: a DONE&out_ready cycle accepts the next op with no bubble on the input side.
- m_flush is combinational from flush, same cycle.
- Flush in REQ in the same cycle as m_in_ready: the multiplier sees flush with the request and is cancelled. The sequencer goes to IDLE.

## Structure
- Shared package mul_pkg: mul_op_e (MUL/MULH/MULHSU/MULHU), mul_seq_state_e, sign-map function op-to-sign, result-select function (op, prod)-to-word.
- Sub-module mul_result_cache: one-entry tag/data register holding a, b, sign, prod and valid, with hit compare. It has write, clear-on-reset and CACHE_EN gating.
- The multiplier itself is instantiated by the parent and connected through the m_* ports.

## Test plan
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF, then MUL with the same operands. Required: m_sign=00 and out_data=0xFFFFFFFE for MULHU. MUL hits with no m_in_valid, out_data=0x00000001 one cycle after accept.
- MULH a=0x80000000, b=0x80000000 -> m_sign=11, out_data=0x40000000. Then MULHSU with the same operands misses (sign 10) and returns 0xC0000000.
- Hold out_ready=0 for 5 cycles after a miss completes. Required: out_valid, out_data and out_tag stay stable, and in_ready=0 until out_ready rises.
- Assert flush in BUSY one cycle before m_out_valid is due. Required: m_flush=1 the same cycle, state returns to IDLE, and no out_valid appears. The cache still hits on the previous operands.
- Assert reset asynchronously mid-REQ. Required: m_in_valid, out_valid and m_out_ready drop immediately and the cache is invalid. The next identical op misses.
- With CACHE_EN=0, issue repeated identical MUL ops. Every op issues m_in_valid and results stay correct.
